// File: rtl/status_reg_if.sv
// Bus between the CPU core/ALU and the 6502 status register (P).
// master drives the ALU/decode side, slave is the status register itself.
interface status_reg_if;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic [3:0] flag_we;
    logic       bit_op;
    logic [7:0] data_in;
    logic       pull;
    logic       pull_rti;
    logic [2:0] flag_op;
    logic       irq_entry;
    logic       sync;
    logic       push_brk;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry_flag;
    logic       decimal_mode;
    logic       irq_mask;

    modport master (
        output alu_result, alu_carry, alu_overflow, flag_we, bit_op, data_in,
               pull, pull_rti, flag_op, irq_entry, sync, push_brk,
        input  p_out, p_push, carry_flag, decimal_mode, irq_mask
    );

    modport slave (
        input  alu_result, alu_carry, alu_overflow, flag_we, bit_op, data_in,
               pull, pull_rti, flag_op, irq_entry, sync, push_brk,
        output p_out, p_push, carry_flag, decimal_mode, irq_mask
    );
endinterface

// File: rtl/status_reg.sv
// 6502 processor status register with instruction-delayed interrupt mask.
// Define STATUS_DECIMAL_EN to store the D flag; otherwise D reads as 0.
//
//   state   | meaning
//   IDLE    | irq_mask agrees with the last committed I write
//   PENDING | I was written by CLI/SEI/PLP; mask waits for the next sync
module status_reg (
    input  logic         clk,
    input  logic         rst,
    status_reg_if.slave  bus
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t state, state_nx;
    logic   n_r, v_r, d_r, i_r, z_r, c_r;
    logic   n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
    logic   mask_r, mask_nx;
    logic   pend_val, pend_val_nx;
    logic   i_wr, mask_clr;

    always_comb begin
        n_nx        = n_r;
        v_nx        = v_r;
        d_nx        = d_r;
        i_nx        = i_r;
        z_nx        = z_r;
        c_nx        = c_r;
        mask_nx     = mask_r;
        pend_val_nx = pend_val;
        state_nx    = state;
        i_wr        = 1'b0;
        mask_clr    = 1'b0;

        if (bus.pull) begin
            n_nx = bus.data_in[7];
            v_nx = bus.data_in[6];
`ifdef STATUS_DECIMAL_EN
            d_nx = bus.data_in[3];
`endif
            i_nx = bus.data_in[2];
            z_nx = bus.data_in[1];
            c_nx = bus.data_in[0];
            if (bus.pull_rti) begin
                mask_nx  = bus.data_in[2];
                mask_clr = 1'b1;
            end else begin
                i_wr = 1'b1;
            end
        end else if (bus.irq_entry) begin
            i_nx     = 1'b1;
            mask_nx  = 1'b1;
            mask_clr = 1'b1;
        end else if (bus.flag_op != 3'd0) begin
            case (bus.flag_op)
                3'd1: c_nx = 1'b0;
                3'd2: c_nx = 1'b1;
                3'd3: begin i_nx = 1'b0; i_wr = 1'b1; end
                3'd4: begin i_nx = 1'b1; i_wr = 1'b1; end
                3'd5: v_nx = 1'b0;
`ifdef STATUS_DECIMAL_EN
                3'd6: d_nx = 1'b0;
                3'd7: d_nx = 1'b1;
`endif
                default: ;
            endcase
        end else if (bus.bit_op) begin
            n_nx = bus.data_in[7];
            v_nx = bus.data_in[6];
            z_nx = (bus.alu_result == 8'h00);
        end else begin
            if (bus.flag_we[3]) n_nx = bus.alu_result[7];
            if (bus.flag_we[2]) z_nx = (bus.alu_result == 8'h00);
            if (bus.flag_we[1]) c_nx = bus.alu_carry;
            if (bus.flag_we[0]) v_nx = bus.alu_overflow;
        end

        // A fresh I write outranks a sync in the same cycle and restarts the wait.
        if (mask_clr) begin
            state_nx = IDLE;
        end else if (i_wr) begin
            state_nx    = PENDING;
            pend_val_nx = i_nx;
        end else if (state == PENDING && bus.sync) begin
            mask_nx  = pend_val;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_r      <= 1'b0;
            v_r      <= 1'b0;
            d_r      <= 1'b0;
            i_r      <= 1'b1;
            z_r      <= 1'b0;
            c_r      <= 1'b0;
            mask_r   <= 1'b1;
            pend_val <= 1'b0;
            state    <= IDLE;
        end else begin
            n_r      <= n_nx;
            v_r      <= v_nx;
            d_r      <= d_nx;
            i_r      <= i_nx;
            z_r      <= z_nx;
            c_r      <= c_nx;
            mask_r   <= mask_nx;
            pend_val <= pend_val_nx;
            state    <= state_nx;
        end
    end

`ifdef STATUS_DECIMAL_EN
    logic unused_bits;
    assign unused_bits = ^bus.data_in[5:4];
`else
    logic unused_bits;
    assign unused_bits = ^bus.data_in[5:3];
`endif

    assign bus.p_out        = {n_r, v_r, 1'b1, 1'b0, d_r, i_r, z_r, c_r};
    assign bus.p_push       = {n_r, v_r, 1'b1, bus.push_brk, d_r, i_r, z_r, c_r};
    assign bus.carry_flag   = c_r;
    assign bus.decimal_mode = d_r;
    assign bus.irq_mask     = mask_r;
endmodule

// File: tb/tb_status_reg.sv
// Testbench for status_reg: directed test-plan cases plus random stimulus
// against a flag-level reference model.
module tb_status_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    status_reg_if bus();

    status_reg dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // reference state: individual flags plus an optional pending mask value
    bit m_n, m_v, m_d, m_i, m_z, m_c, m_mask;
    bit m_pend_on, m_pend_val;

`ifdef STATUS_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_p();
        return {m_n, m_v, 1'b1, 1'b0, m_d, m_i, m_z, m_c};
    endfunction

    task automatic clear_inputs();
        bus.alu_result = 8'h00; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b0;
        bus.flag_we = 4'b0000;  bus.bit_op = 1'b0;    bus.data_in = 8'h00;
        bus.pull = 1'b0;        bus.pull_rti = 1'b0;  bus.flag_op = 3'd0;
        bus.irq_entry = 1'b0;   bus.sync = 1'b0;      bus.push_brk = 1'b0;
        rst = 1'b0;
    endtask

    // One clock of the architectural rules, applied to the inputs present at the edge.
    task automatic model_update();
        bit i_written = 1'b0;
        bit mask_forced = 1'b0;
        if (rst) begin
            {m_n, m_v, m_d, m_i, m_z, m_c} = 6'b000100;
            m_mask = 1'b1; m_pend_on = 1'b0;
            return;
        end
        if (bus.pull) begin
            m_n = bus.data_in[7]; m_v = bus.data_in[6];
            if (DEC_EN) m_d = bus.data_in[3];
            m_i = bus.data_in[2]; m_z = bus.data_in[1]; m_c = bus.data_in[0];
            if (bus.pull_rti) begin m_mask = bus.data_in[2]; mask_forced = 1'b1; end
            else i_written = 1'b1;
        end else if (bus.irq_entry) begin
            m_i = 1'b1; m_mask = 1'b1; mask_forced = 1'b1;
        end else if (bus.flag_op != 3'd0) begin
            unique case (bus.flag_op)
                3'd1: m_c = 1'b0;
                3'd2: m_c = 1'b1;
                3'd3: begin m_i = 1'b0; i_written = 1'b1; end
                3'd4: begin m_i = 1'b1; i_written = 1'b1; end
                3'd5: m_v = 1'b0;
                3'd6: if (DEC_EN) m_d = 1'b0;
                3'd7: if (DEC_EN) m_d = 1'b1;
                default: ;
            endcase
        end else if (bus.bit_op) begin
            m_n = bus.data_in[7]; m_v = bus.data_in[6]; m_z = (bus.alu_result == 0);
        end else begin
            if (bus.flag_we[3]) m_n = bus.alu_result[7];
            if (bus.flag_we[2]) m_z = (bus.alu_result == 0);
            if (bus.flag_we[1]) m_c = bus.alu_carry;
            if (bus.flag_we[0]) m_v = bus.alu_overflow;
        end
        if (mask_forced) m_pend_on = 1'b0;
        else if (i_written) begin m_pend_on = 1'b1; m_pend_val = m_i; end
        else if (m_pend_on && bus.sync) begin m_mask = m_pend_val; m_pend_on = 1'b0; end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".p_out"},  bus.p_out, model_p());
        check({tag, ".p_push"}, bus.p_push, model_p() | {3'b000, bus.push_brk, 4'b0000});
        check({tag, ".carry"},  {7'd0, bus.carry_flag},   {7'd0, m_c});
        check({tag, ".dec"},    {7'd0, bus.decimal_mode}, {7'd0, m_d});
        check({tag, ".mask"},   {7'd0, bus.irq_mask},     {7'd0, m_mask});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step("reset");
        step("idle");
        check("rst_p_out", bus.p_out, 8'h24);
        check("rst_mask", {7'd0, bus.irq_mask}, 8'h01);
        check("rst_carry", {7'd0, bus.carry_flag}, 8'h00);
        bus.push_brk = 1'b1; #1;
        check("rst_p_push_brk", bus.p_push, 8'h34);

        bus.flag_we = 4'b1111; bus.alu_result = 8'h00; bus.alu_carry = 1'b1; bus.alu_overflow = 1'b1;
        step("we_all");
        check("we_all_p", bus.p_out, 8'h67);

        // CLI with sync in the same cycle, then sync three cycles later
        bus.flag_op = 3'd3; bus.sync = 1'b1;
        step("cli_t1");
        check("cli_i_t1", {7'd0, bus.p_out[2]}, 8'h00);
        check("cli_mask_t1", {7'd0, bus.irq_mask}, 8'h01);
        step("cli_t2");
        check("cli_mask_t2", {7'd0, bus.irq_mask}, 8'h01);
        step("cli_t3");
        bus.sync = 1'b1; #1;
        check("cli_mask_t3", {7'd0, bus.irq_mask}, 8'h01);
        step("cli_t4");
        check("cli_mask_t4", {7'd0, bus.irq_mask}, 8'h00);

        // SEI overtakes a pending CLI
        rst = 1'b1; step("rst2");
        bus.flag_op = 3'd3; step("cli2");
        bus.flag_op = 3'd4; step("sei2");
        for (int k = 0; k < 3; k++) begin bus.sync = 1'b1; step("sei2_sync"); end
        check("sei_keeps_mask", {7'd0, bus.irq_mask}, 8'h01);

        // reset while pending discards the update
        bus.flag_op = 3'd3; step("cli3");
        rst = 1'b1; step("rst3");
        bus.sync = 1'b1; step("rst3_sync");
        check("rst_pending_mask", {7'd0, bus.irq_mask}, 8'h01);

        bus.pull = 1'b1; bus.pull_rti = 1'b1; bus.data_in = 8'hFF;
        step("rti_ff");
        check("rti_ff_p", bus.p_out, DEC_EN ? 8'hEF : 8'hE7);
        check("rti_ff_mask", {7'd0, bus.irq_mask}, 8'h01);
        bus.pull = 1'b1; bus.pull_rti = 1'b1; bus.data_in = 8'h00;
        step("rti_00");
        check("rti_00_mask", {7'd0, bus.irq_mask}, 8'h00);

        bus.flag_op = 3'd2; step("sec");
        bus.pull = 1'b1; bus.data_in = 8'h00; bus.flag_op = 3'd2; bus.flag_we = 4'b0010;
        bus.alu_carry = 1'b1;
        step("prio");
        check("prio_p", bus.p_out, 8'h20);
        check("prio_c", {7'd0, bus.carry_flag}, 8'h00);

        bus.flag_op = 3'd2; step("sec2");
        bus.bit_op = 1'b1; bus.data_in = 8'hC0; bus.alu_result = 8'h00;
        step("bit");
        check("bit_p", bus.p_out, 8'hE3);
        bus.flag_op = 3'd7; step("sed");
        check("sed_dec", {7'd0, bus.decimal_mode}, {7'd0, DEC_EN});

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            rst              = ($urandom_range(0, 63) == 0);
            bus.alu_result   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bus.alu_carry    = 1'($urandom);
            bus.alu_overflow = 1'($urandom);
            bus.flag_we      = 4'($urandom);
            bus.bit_op       = ($urandom_range(0, 5) == 0);
            bus.data_in      = 8'($urandom);
            bus.pull         = ($urandom_range(0, 7) == 0);
            bus.pull_rti     = 1'($urandom);
            bus.flag_op      = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
            bus.irq_entry    = ($urandom_range(0, 15) == 0);
            bus.sync         = ($urandom_range(0, 2) == 0);
            bus.push_brk     = 1'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/status_reg.md
# status_reg

6502 processor status register (P), directly downstream of the ALU. Latches N/Z/C/V from the ALU result and flag outputs under per-flag update strobes. Executes flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), BIT, PLP/RTI pulls and interrupt entry. Feeds `carry_flag` and `decimal_mode` back to the ALU and an instruction-delayed `irq_mask` to interrupt logic.

## Interface
Parameters: none.

Clock and reset:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.

Inputs:
- `alu_result` in 8: ALU `hold_reg`.
- `alu_carry` in 1: ALU `carry_out`.
- `alu_overflow` in 1: ALU `overflow`.
- `flag_we` in 4: update strobes {N,Z,C,V} from ALU outputs.
- `bit_op` in 1: BIT: N<=data_in[7], V<=data_in[6], Z<=(alu_result==0).
- `data_in` in 8: pulled stack byte (PLP/RTI) or BIT operand.
- `pull` in 1: load P from `data_in`.
- `pull_rti` in 1: qualifies `pull` as RTI (immediate mask update).
- `flag_op` in 3: 0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- `irq_entry` in 1: interrupt sequence; sets I.
- `sync` in 1: opcode-fetch strobe (instruction boundary).
- `push_brk` in 1: B value for `p_push`.

Outputs:
- `p_out` out 8: {N,V,1,0,D,I,Z,C}.
- `p_push` out 8: `p_out` with bit4 = `push_brk` (combinational).
- `carry_flag` out 1: C, to ALU `carry_in`.
- `decimal_mode` out 1: D, to ALU `decimal_mode`.
- `irq_mask` out 1: effective I for interrupt polling.

## Operation
- State: N,V,D,I,Z,C; `mask_r`; `pend`, `pend_val`.
- Per-cycle priority, highest first: `rst` > `pull` > `irq_entry` > `flag_op` > `bit_op` > `flag_we`. Only the highest active source writes; lower sources are ignored that cycle, including for flags the winner does not touch.
- `flag_we` bit semantics:
  - N <= alu_result[7]
  - Z <= (alu_result == 0)
  - C <= alu_carry
  - V <= alu_overflow
  - Bits are independent; any subset may be set together.
- `pull`: loads N,V,D,I,Z,C from data_in bits 7,6,3,2,1,0. Bits 5 and 4 are discarded; `p_out` bit5 is always 1, bit4 always 0.
- `flag_op` touches only its flag. Codes 3/4 change I; 6/7 change D.
- I-mask delay state machine, states IDLE / PENDING:
  - CLI, SEI or a non-RTI `pull` writing I: set `pend`=1, `pend_val`=new I; enter PENDING.
  - PENDING: at the first `sync` in a cycle strictly after the write cycle, `mask_r`<=`pend_val`, `pend`<=0; return to IDLE.
  - A newer I write while PENDING replaces `pend_val` and restarts the wait.
  - `pull` with `pull_rti`: `mask_r`<=data_in[2] immediately; clears `pend`.
  - `irq_entry`: I<=1, `mask_r`<=1; clears `pend`.
- `irq_mask` = `mask_r`.

## Timing
- All outputs except `p_push` are registered; an update is visible the cycle after its strobe.
- Reset values:
  - `p_out`=8'h24 (I=1, all other flags 0)
  - `carry_flag`=0, `decimal_mode`=0, `irq_mask`=1
  - `pend`=0, state IDLE
  - `p_push`=8'h24 | (`push_brk`<<4)
- `rst` mid-PENDING discards the pending update.
- `sync` in the same cycle as the I write does not complete PENDING.
- CLI/SEI: `irq_mask` changes one cycle after the next qualifying `sync`.
- RTI / `irq_entry`: `irq_mask` changes the next cycle.

## Configuration
- `STATUS_DECIMAL_EN` defined: D is stored; CLD/SED and `pull` write it; `decimal_mode` = D.
- `STATUS_DECIMAL_EN` undefined:
  - D is held at 0; CLD/SED and the `pull` bit3 are ignored.
  - `p_out[3]`=0 and `decimal_mode`=0.
  - Matches the ALU's BCD-less operation.

## Test plan
- Reset, then idle: `p_out`=8'h24, `irq_mask`=1, `carry_flag`=0. `push_brk`=1 gives `p_push`=8'h34.
- `flag_we`=4'b1111 with `alu_result`=8'h00, `alu_carry`=1, `alu_overflow`=1 -> next cycle `p_out`=8'h67.
- CLI at cycle t, `sync` at t and t+3:
  - I=0 at t+1; `irq_mask` stays 1 through t+3 and becomes 0 at t+4.
  - SEI before t+3 instead keeps `irq_mask`=1.
- `pull`=1 with `data_in`=8'hFF, `pull_rti`=1 -> `p_out`=8'hEF (8'hE7 without `STATUS_DECIMAL_EN`), `irq_mask`=1 the next cycle. Same with `data_in`=8'h00 -> `irq_mask`=0 the next cycle.
- Simultaneous `pull` (`data_in`=8'h00), `flag_op`=SEC and `flag_we`=4'b0010 -> C=0, `p_out`=8'h20.
- `bit_op` with `data_in`=8'hC0, `alu_result`=8'h00 -> N=1, V=1, Z=1, C unchanged. SED -> `decimal_mode`=1 with macro, 0 without.
